// File: rtl/rx_descrambler.sv
// rx_descrambler: 64b/66b receive descrambler (x^58+x^39+1) with lock/priming gating.
// Optional BER monitor built when RX_DESCRAMBLER_BER_MON_EN is defined; otherwise hi_ber is 0.
module rx_descrambler #(
  parameter int WINDOW_CYCLES = 19531,
  parameter int BER_THRESH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] data_in,
  input  logic        block_locked,
  output logic [65:0] data_out,
  output logic        data_valid,
  output logic        sh_err,
  output logic        hi_ber
);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] PRIME    = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  logic [57:0]  scr_q, scr_d;
  logic [1:0]   state_q, state_d;
  logic [65:0]  data_out_q, data_out_d;
  logic         data_valid_q, data_valid_d;
  logic         sh_err_q, sh_err_d;
  logic         hdr_bad;
  logic [121:0] hist;
  // hist[i] is the received bit at time i-58 relative to this block's first payload bit
  always_comb begin
    hist = '0;
    for (int k = 0; k < 58; k++) hist[57-k] = scr_q[k];
    hist[121:58] = data_in[65:2];
    data_out_d = {64'h0, data_in[1:0]};
    for (int j = 0; j < 64; j++) data_out_d[2+j] = hist[58+j] ^ hist[19+j] ^ hist[j];
    for (int k = 0; k < 58; k++) scr_d[k] = hist[121-k];
    state_d = !block_locked ? UNLOCKED : (state_q == UNLOCKED ? PRIME : RUN);
    data_valid_d = block_locked & (state_q != UNLOCKED);
    hdr_bad = data_in[1] == data_in[0];
    sh_err_d = data_valid_d & hdr_bad;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scr_q        <= '0;
      state_q      <= UNLOCKED;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sh_err_q     <= 1'b0;
    end else begin
      scr_q        <= scr_d;
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sh_err_q     <= sh_err_d;
    end
  end
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sh_err     = sh_err_q;
`ifdef RX_DESCRAMBLER_BER_MON_EN
  localparam int WW = WINDOW_CYCLES > 1 ? $clog2(WINDOW_CYCLES) : 1;
  localparam int EW = $clog2(BER_THRESH + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] err_q, err_d, err_now;
  logic          hi_ber_q, hi_ber_d, counting, win_end;
  always_comb begin
    counting = (state_q == RUN) & block_locked;
    win_end  = win_q == WIN_LAST;
    err_now  = (hdr_bad && err_q < EW'(BER_THRESH)) ? err_q + EW'(1) : err_q;
    win_d    = (counting && !win_end) ? win_q + WW'(1) : '0;
    err_d    = (counting && !win_end) ? err_now : '0;
    hi_ber_d = !counting ? 1'b0 : (win_end ? (err_now >= EW'(BER_THRESH)) : hi_ber_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q    <= '0;
      err_q    <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      err_q    <= err_d;
      hi_ber_q <= hi_ber_d;
    end
  end
  assign hi_ber = hi_ber_q;
`else
  localparam int unused_ber_cfg = WINDOW_CYCLES + BER_THRESH;
  assign hi_ber = 1'b0;
`endif
endmodule

// File: tb/tb_rx_descrambler.sv
// tb_rx_descrambler: randomized and directed checks of rx_descrambler against a bit-history model.
module tb_rx_descrambler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [65:0] data_in = '0;
  logic        block_locked = 1'b0;
  logic [65:0] data_out;
  logic        data_valid, sh_err, hi_ber;
  int          total = 0, bad = 0;
  bit          hist[$];
  bit          prev_lock = 1'b0;
  logic        exp_hi = 1'b0;
`ifdef RX_DESCRAMBLER_BER_MON_EN
  localparam bit BER_ON = 1'b1;
`else
  localparam bit BER_ON = 1'b0;
`endif
  always #5 clk = ~clk;
  rx_descrambler #(.WINDOW_CYCLES(64), .BER_THRESH(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .block_locked(block_locked),
    .data_out(data_out), .data_valid(data_valid), .sh_err(sh_err), .hi_ber(hi_ber)
  );
  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit at(int t);
    return (t < 0) ? 1'b0 : hist[t];
  endfunction
  // transmit-side scrambling of p given the wire history so far
  function automatic logic [63:0] scramble(logic [63:0] p);
    logic [63:0] s;
    int b = hist.size();
    for (int j = 0; j < 64; j++) begin
      int i1 = b + j - 39, i2 = b + j - 58;
      bit t1 = (i1 < 0) ? 1'b0 : (i1 < b ? hist[i1] : s[i1-b]);
      bit t2 = (i2 < 0) ? 1'b0 : (i2 < b ? hist[i2] : s[i2-b]);
      s[j] = p[j] ^ t1 ^ t2;
    end
    return s;
  endfunction
  task automatic step(input logic [63:0] p, input logic [1:0] h, input bit lk, input string tag);
    logic [63:0] e;
    bit ev;
    int b = hist.size();
    for (int j = 0; j < 64; j++) hist.push_back(p[j]);
    for (int j = 0; j < 64; j++) e[j] = hist[b+j] ^ at(b+j-39) ^ at(b+j-58);
    ev = lk & prev_lock;
    prev_lock = lk;
    data_in = {p, h};
    block_locked = lk;
    @(posedge clk); #1;
    chk({tag, ".data"}, data_out, {e, h});
    chk({tag, ".valid"}, 66'(data_valid), 66'(ev));
    chk({tag, ".sh_err"}, 66'(sh_err), 66'(ev & (h[1] == h[0])));
    chk({tag, ".hi_ber"}, 66'(hi_ber), 66'(exp_hi));
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b0;
    data_in = {$urandom, $urandom, 2'($urandom)};
    block_locked = 1'($urandom);
    @(posedge clk); #1;
    chk({tag, ".rst_data"}, data_out, 66'h0);
    chk({tag, ".rst_valid"}, 66'(data_valid), 66'h0);
    chk({tag, ".rst_sh_err"}, 66'(sh_err), 66'h0);
    chk({tag, ".rst_hi_ber"}, 66'(hi_ber), 66'h0);
    reset = 1'b1;
    block_locked = 1'b0;
    hist.delete();
    prev_lock = 1'b0;
    exp_hi = 1'b0;
  endtask
  initial begin
    logic [63:0] p, s;
    logic [1:0]  h;
    // T1 reset and idle unlocked
    @(posedge clk); #1;
    do_reset("t1");
    for (int i = 0; i < 10; i++) step({$urandom, $urandom}, 2'($urandom), 1'b0, "t1.idle");
    // T2 priming with zero payloads
    do_reset("t2");
    step(64'h0, 2'b01, 1'b1, "t2.first");
    step(64'h0, 2'b01, 1'b1, "t2.second");
    chk("t2.const", data_out, 66'h1);
    // T3 impulse response
    do_reset("t3");
    step(64'h1, 2'b01, 1'b1, "t3.impulse");
    chk("t3.taps", data_out, 66'h1000_0200_0000_0005);
    step(64'h0, 2'b10, 1'b1, "t3.tail");
    // T4 round trip through a bench scrambler
    do_reset("t4");
    for (int i = 0; i < 1000; i++) begin
      p = {$urandom, $urandom};
      h = 2'($urandom_range(1, 2));
      s = scramble(p);
      step(s, h, 1'b1, "t4.model");
      if (i > 0) chk("t4.payload", data_out, {p, h});
    end
    // T5 one-cycle lock drop with bad headers around it
    do_reset("t5");
    for (int i = 0; i < 4; i++) step({$urandom, $urandom}, 2'b01, 1'b1, "t5.run");
    step({$urandom, $urandom}, 2'b11, 1'b0, "t5.drop");
    step({$urandom, $urandom}, 2'b11, 1'b1, "t5.reprime");
    step({$urandom, $urandom}, 2'b10, 1'b1, "t5.back");
    chk("t5.valid_again", 66'(data_valid), 66'h1);
    // T6 BER windows of 64 cycles: 16 errors then 15 errors
    do_reset("t6");
    step({$urandom, $urandom}, 2'b01, 1'b1, "t6.prime");
    step({$urandom, $urandom}, 2'b01, 1'b1, "t6.enter");
    for (int c = 0; c < 64; c++) begin
      if (c == 63) exp_hi = BER_ON;
      step({$urandom, $urandom}, c < 16 ? 2'(c[0] ? 2'b11 : 2'b00) : 2'b01, 1'b1, "t6.w1");
    end
    chk("t6.hi_after_w1", 66'(hi_ber), 66'(BER_ON));
    for (int c = 0; c < 64; c++) begin
      if (c == 63) exp_hi = 1'b0;
      step({$urandom, $urandom}, c < 15 ? 2'b11 : 2'b10, 1'b1, "t6.w2");
    end
    chk("t6.hi_after_w2", 66'(hi_ber), 66'h0);
    step({$urandom, $urandom}, 2'b01, 1'b0, "t6.leave");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
